// File: rtl/chess_pkg.sv
// Shared definitions for the move-generation slice.
// Contents: board coordinate and slot geometry, the empty-slot encoding,
// piece codes, and the move_serializer state enum.
package chess_pkg;

  localparam int unsigned COORD_W = 6;           // {x[2:0], y[2:0]}
  localparam int unsigned SLOTS   = 8;           // origin slots per FIFO word
  localparam int unsigned MOVE_W  = 2 * COORD_W; // {from, to}
  localparam int unsigned CNT_W   = 8;

  // PVOID origin: a slot holding this value carries no move.
  localparam logic [COORD_W-1:0] EMPTY_SLOT = 6'o00;

  typedef enum logic [2:0] {
    PVOID  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_COLLECT,
    SER_EMIT,
    SER_FINISH
  } ser_state_e;

endpackage

// File: rtl/slot_priority_sel.sv
// Lowest-set-bit encoder over a slot mask.
// Ports:
//   mask - one bit per slot, bit 0 has highest priority
//   idx  - index of the lowest set bit (0 when mask is empty)
//   any  - mask has at least one bit set
module slot_priority_sel #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         mask,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !any) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_serializer.sv
// Serializes per-square FIFO words (SLOTS packed origin coordinates plus the
// producing square's destination) into a stream of {from, to} moves, one per
// handshake, skipping empty slots and flagging end-of-list.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   start                   - new board pulse; aborts and clears everything
//   in_valid/in_ready       - FIFO word handshake (in_word, in_dest)
//   src_done                - all square units finished
//   mv_valid/mv_ready       - move handshake (mv_data = {from, to})
//   list_done               - level, move list complete for this board
//   busy                    - in COLLECT or EMIT
//   move_count              - handshaken moves since start
// Build option: define MOVE_COUNT_EN to build the saturating move counter;
// otherwise move_count is tied to zero.
module move_serializer #(
  parameter int unsigned SLOTS   = chess_pkg::SLOTS,
  parameter int unsigned COORD_W = chess_pkg::COORD_W,
  parameter int unsigned CNT_W   = chess_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLOTS*COORD_W-1:0] in_word,
  input  logic [COORD_W-1:0]       in_dest,
  input  logic                     src_done,
  output logic                     mv_valid,
  input  logic                     mv_ready,
  output logic [2*COORD_W-1:0]     mv_data,
  output logic                     list_done,
  output logic                     busy,
  output logic [CNT_W-1:0]         move_count
);

  import chess_pkg::*;

  localparam int unsigned IDX_W = $clog2(SLOTS);

  ser_state_e state_q, state_d;

  logic [COORD_W-1:0] word_q [SLOTS];
  logic [COORD_W-1:0] dest_q;
  logic [SLOTS-1:0]   mask_q;
  logic [SLOTS-1:0]   in_mask;
  logic [SLOTS-1:0]   sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               take_word;
  logic               mv_fire;
  logic               last_move;

  // Slot 0 sits in the most significant field of the FIFO word.
  always_comb begin
    in_mask = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      in_mask[i] = (in_word[(SLOTS-1-i)*COORD_W +: COORD_W] != COORD_W'(EMPTY_SLOT));
    end
  end

  slot_priority_sel #(
    .N (SLOTS)
  ) u_sel (
    .mask (mask_q),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  assign sel_onehot = SLOTS'(1) << sel_idx;
  assign take_word  = (state_q == SER_COLLECT) && in_valid;
  assign mv_fire    = (state_q == SER_EMIT) && sel_any && mv_ready;
  assign last_move  = (mask_q & ~sel_onehot) == '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SER_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SER_COLLECT;
    end else begin
      unique case (state_q)
        SER_IDLE:    state_d = SER_IDLE;
        SER_COLLECT: begin
          // A pending word is always taken before end-of-list is honoured.
          if (in_valid) begin
            if (|in_mask) state_d = SER_EMIT;
          end else if (src_done) begin
            state_d = SER_FINISH;
          end
        end
        SER_EMIT: begin
          if (!sel_any || (mv_ready && last_move)) state_d = SER_COLLECT;
        end
        SER_FINISH:  state_d = SER_FINISH;
        default:     state_d = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      dest_q <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) word_q[i] <= '0;
    end else if (start) begin
      mask_q <= '0;
      dest_q <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) word_q[i] <= '0;
    end else if (take_word) begin
      mask_q <= in_mask;
      dest_q <= in_dest;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        word_q[i] <= in_word[(SLOTS-1-i)*COORD_W +: COORD_W];
      end
    end else if (mv_fire) begin
      mask_q <= mask_q & ~sel_onehot;
    end
  end

  assign in_ready  = (state_q == SER_COLLECT);
  assign mv_valid  = (state_q == SER_EMIT) && sel_any;
  assign mv_data   = mv_valid ? {word_q[sel_idx], dest_q} : '0;
  assign list_done = (state_q == SER_FINISH);
  assign busy      = (state_q == SER_COLLECT) || (state_q == SER_EMIT);

`ifdef MOVE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        count_q <= '0;
    else if (start)                      count_q <= '0;
    else if (mv_fire && count_q != '1)   count_q <= count_q + 1'b1;
  end

  assign move_count = count_q;
`else
  assign move_count = '0;
`endif

endmodule

// File: tb/tb_move_serializer.sv
// Directed bench for move_serializer: a mid-run reset sequence followed by a
// cycle-by-cycle vector table of inputs and expected outputs.
module tb_move_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_word = '0;
  logic [5:0]  in_dest = '0;
  logic        src_done = 1'b0;
  logic        mv_valid;
  logic        mv_ready = 1'b0;
  logic [11:0] mv_data;
  logic        list_done;
  logic        busy;
  logic [7:0]  move_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  move_serializer #(
    .SLOTS   (8),
    .COORD_W (6),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_dest    (in_dest),
    .src_done   (src_done),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_data    (mv_data),
    .list_done  (list_done),
    .busy       (busy),
    .move_count (move_count)
  );

  typedef struct {
    logic        st;
    logic        iv;
    logic [47:0] w;
    logic [5:0]  d;
    logic        sd;
    logic        mr;
    logic        ir;
    logic        mv;
    logic [11:0] md;
    logic        ld;
    logic        bz;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic iv, input logic [47:0] w,
                     input logic [5:0] d, input logic sd, input logic mr,
                     input logic ir, input logic mv, input logic [11:0] md,
                     input logic ld, input logic bz, input logic [7:0] cnt);
    vec_t v;
    v.st = st; v.iv = iv; v.w = w; v.d = d; v.sd = sd; v.mr = mr;
    v.ir = ir; v.mv = mv; v.md = md; v.ld = ld; v.bz = bz; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input logic [7:0] c);
`ifdef MOVE_COUNT_EN
    return c;
`else
    return 8'd0;
`endif
  endfunction

  logic [47:0] w1, wf, w3, w5;

  initial begin
    w1 = {6'o12, 6'o00, 6'o00, 6'o34, 24'h0};
    w3 = {6'o11, 6'o22, 6'o33, 30'h0};
    w5 = {6'o05, 42'h0};
    for (int i = 0; i < 8; i++) wf[(7-i)*6 +: 6] = 6'(i + 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  32'(in_ready), 0);
    chk("rst.mv_valid",  32'(mv_valid), 0);
    chk("rst.mv_data",   32'(mv_data), 0);
    chk("rst.list_done", 32'(list_done), 0);
    chk("rst.busy",      32'(busy), 0);
    chk("rst.count",     32'(move_count), 0);
    reset_n = 1'b1;

    // Mid-run reset: bring a word into EMIT, then assert reset asynchronously.
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; in_valid = 1'b1; in_word = w1; in_dest = 6'o25; end
    @(negedge clk) begin in_valid = 1'b0; mv_ready = 1'b0; end
    begin
      int n = 0;
      while (!mv_valid && n < 5) begin @(negedge clk); n++; end
    end
    chk("mid.mv_valid", 32'(mv_valid), 1);
    chk("mid.mv_data",  32'(mv_data), 32'(12'o1225));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst.mv_valid", 32'(mv_valid), 0);
    chk("mid_rst.mv_data",  32'(mv_data), 0);
    chk("mid_rst.busy",     32'(busy), 0);
    chk("mid_rst.in_ready", 32'(in_ready), 0);
    @(negedge clk) reset_n = 1'b1;

    // Vector table: inputs applied for one cycle, outputs expected in that cycle.
    //   st iv w    d      sd mr   ir mv md         ld bz cnt
    add(0, 0, '0, '0,    0, 0,   0, 0, '0,        0, 0, 0);  // IDLE
    add(1, 0, '0, '0,    0, 0,   0, 0, '0,        0, 0, 0);  // start
    add(0, 1, w1, 6'o25, 0, 1,   1, 0, '0,        0, 1, 0);  // accept
    add(0, 0, '0, '0,    0, 1,   0, 1, 12'o1225,  0, 1, 0);
    add(0, 0, '0, '0,    0, 1,   0, 1, 12'o3425,  0, 1, 1);
    add(0, 0, '0, '0,    0, 1,   1, 0, '0,        0, 1, 2);
    // backpressure
    add(0, 1, w1, 6'o25, 0, 0,   1, 0, '0,        0, 1, 2);
    add(0, 0, '0, '0,    0, 0,   0, 1, 12'o1225,  0, 1, 2);
    add(0, 0, '0, '0,    0, 0,   0, 1, 12'o1225,  0, 1, 2);
    add(0, 0, '0, '0,    0, 0,   0, 1, 12'o1225,  0, 1, 2);
    add(0, 0, '0, '0,    0, 1,   0, 1, 12'o1225,  0, 1, 2);
    add(0, 0, '0, '0,    0, 1,   0, 1, 12'o3425,  0, 1, 3);
    // all-zero word consumed silently, then start clears the counter
    add(0, 1, '0, 6'o25, 0, 1,   1, 0, '0,        0, 1, 4);
    add(1, 0, '0, '0,    0, 1,   1, 0, '0,        0, 1, 4);
    // full word, dest 00, then end of list
    add(0, 1, wf, 6'o00, 0, 1,   1, 0, '0,        0, 1, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, '0, '0,  0, 1,   0, 1, {6'(i + 1), 6'o00}, 0, 1, 8'(i));
    add(0, 0, '0, '0,    1, 1,   1, 0, '0,        0, 1, 8);
    add(0, 0, '0, '0,    0, 1,   0, 0, '0,        1, 0, 8);
    add(1, 0, '0, '0,    0, 0,   0, 0, '0,        1, 0, 8);  // start from FINISH
    // start during EMIT after first of three moves
    add(0, 1, w3, 6'o44, 0, 1,   1, 0, '0,        0, 1, 0);
    add(0, 0, '0, '0,    0, 1,   0, 1, 12'o1144,  0, 1, 0);
    add(1, 0, '0, '0,    0, 1,   0, 1, 12'o2244,  0, 1, 1);
    add(0, 0, '0, '0,    0, 1,   1, 0, '0,        0, 1, 0);
    add(0, 0, '0, '0,    0, 1,   1, 0, '0,        0, 1, 0);
    // in_valid and src_done together: word first, FINISH afterwards
    add(0, 1, w5, 6'o07, 1, 1,   1, 0, '0,        0, 1, 0);
    add(0, 0, '0, '0,    1, 1,   0, 1, 12'o0507,  0, 1, 0);
    add(0, 0, '0, '0,    1, 1,   1, 0, '0,        0, 1, 1);
    add(0, 0, '0, '0,    0, 0,   0, 0, '0,        1, 0, 1);

    foreach (vecs[k]) begin
      start    = vecs[k].st;
      in_valid = vecs[k].iv;
      in_word  = vecs[k].w;
      in_dest  = vecs[k].d;
      src_done = vecs[k].sd;
      mv_ready = vecs[k].mr;
      #1;
      chk($sformatf("v%0d.in_ready", k),  32'(in_ready),   32'(vecs[k].ir));
      chk($sformatf("v%0d.mv_valid", k),  32'(mv_valid),   32'(vecs[k].mv));
      chk($sformatf("v%0d.mv_data", k),   32'(mv_data),    32'(vecs[k].md));
      chk($sformatf("v%0d.list_done", k), 32'(list_done),  32'(vecs[k].ld));
      chk($sformatf("v%0d.busy", k),      32'(busy),       32'(vecs[k].bz));
      chk($sformatf("v%0d.count", k),     32'(move_count), 32'(cnt_exp(vecs[k].cnt)));
      @(negedge clk);
    end

    start = 1'b0; in_valid = 1'b0; src_done = 1'b0; mv_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_serializer.md
Name: move_serializer

Overview:
- Sits directly downstream of the per-square move FIFOs.
- Takes one 48-bit FIFO word (8 packed 6-bit origin coordinates) plus the destination square coordinate, and emits one 12-bit move {from, to} per handshake on a single output stream.
- Skips empty slots and signals end-of-list once the square array reports done and no words are pending.
- Feeds the move-list store / search control.

Parameters:
- SLOTS, 8, origin slots per FIFO word.
- COORD_W, 6, coordinate width {x[2:0], y[2:0]}.
- CNT_W, 8, move counter width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse: a new board has been issued; clears internal state.
- in_valid  input  1  FIFO word available.
- in_ready  output  1  word accepted when in_valid && in_ready.
- in_word  input  SLOTS*COORD_W  origins; slot 0 = bits [47:42], slot 7 = bits [5:0].
- in_dest  input  COORD_W  destination square {xpos, ypos} of the producing square unit.
- src_done  input  1  AND of all square-unit done outputs.
- mv_valid  output  1  move present.
- mv_ready  input  1  consumer accepts the move.
- mv_data  output  2*COORD_W  {from[5:0], to[5:0]}.
- list_done  output  1  level: move list complete for this board.
- busy  output  1  high in COLLECT or EMIT.
- move_count  output  CNT_W  moves emitted since start (feature-gated).

Behaviour:
- Reset (async, reset_n low): state IDLE; in_ready, mv_valid, list_done, busy = 0; mv_data = 0; move_count = 0; latched word and mask = 0.
- Empty slot encoding: 6'o00 (PVOID origin). A non-zero slot is a move.
- States: IDLE, COLLECT, EMIT, FINISH.
- IDLE: all outputs idle; start -> COLLECT.
- COLLECT:
  - in_ready = 1.
  - On in_valid: latch in_word and in_dest; build slot mask (bit i = slot i non-zero).
  - Mask non-zero -> EMIT. Mask zero -> stay in COLLECT; the word is consumed with no output.
  - Else if src_done && !in_valid -> FINISH.
  - in_valid takes priority over src_done in the same cycle.
- EMIT:
  - in_ready = 0; mv_valid = 1.
  - mv_data = {slot[k], dest}, where k is the lowest set mask bit.
  - On mv_valid && mv_ready: clear mask bit k. If it was the last set bit -> COLLECT next cycle; otherwise present the next slot in the following cycle.
  - Throughput: one move per cycle while mv_ready is held high.
- Latency: word accepted at cycle N -> first mv_valid at N+1.
- Backpressure: mv_data and mv_valid stay stable while !mv_ready.
- FINISH: list_done = 1, busy = 0; holds until start or reset.
- start in any state: abort, discard the latched word and mask, drop mv_valid, clear move_count -> COLLECT next cycle. start wins over every other event in the same cycle.
- busy = (state == COLLECT) || (state == EMIT).

Optional Feature:
- Macro: MOVE_COUNT_EN.
- Defined: move_count increments on each mv handshake, saturates at 2^CNT_W-1, and clears on start or reset.
- Undefined: the move_count port remains and is tied to 0; the counter logic is not built.

Decomposition:
- Shared package chess_pkg: COORD_W, SLOTS, MOVE_W = 2*COORD_W, EMPTY_SLOT = 6'o00, piece codes, serializer state enum.
- One natural sub-module: slot_priority_sel, a combinational lowest-set-bit encoder over the SLOTS-bit mask that returns index k and an any flag.

Test Plan:
- Reset mid-run then release; start; word {6'o12, 6'o00, 6'o00, 6'o34, 0, 0, 0, 0}, dest 6'o25, mv_ready = 1 -> mv_data 12'o1225 then 12'o3425 on consecutive cycles; in_ready high the cycle after; move_count = 2.
- Same word with mv_ready low for 3 cycles -> mv_data held at 12'o1225 with mv_valid = 1 throughout; second move follows the first handshake.
- All-zero word -> consumed in 1 cycle; mv_valid never rises; in_ready stays 1.
- Full word (8 non-zero slots), dest 6'o00 -> 8 moves in 8 cycles in slot order 0..7; then src_done = 1 and in_valid = 0 -> list_done = 1 next cycle; move_count = 8.
- start pulsed during EMIT after 1 of 3 moves -> mv_valid = 0 next cycle; move_count = 0; state COLLECT; no remaining moves emitted.
- Simultaneous in_valid and src_done in COLLECT -> word accepted, FINISH deferred until the word drains and in_valid is low.
